sign_extender: RTL and testbench
================================

Name:
sign_extender

Overview:
- Parameterised immediate sign extender for the 16-bit MERC-16 datapath.
- Takes a 16-bit word whose low SIGN_BIT+1 bits hold a two's-complement immediate. Produces the 16-bit sign-extended value.
- Used by decode for 4-, 8- and 11-bit immediate fields, with SIGN_BIT = 3, 7 and 10.
- Output is registered: one clock of latency, synchronous active-high reset.

Parameters:
- DATA_WIDTH, 16: width of In, Out and SignRail. Only 16 is supported.
- SIGN_BIT, 3: bit index of the immediate's sign bit. Legal range 0..DATA_WIDTH-1. A value of DATA_WIDTH-1 makes the block a plain register.

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- In  input  16  raw word; bits [SIGN_BIT:0] are the immediate, bits above SIGN_BIT are don't-care.
- InValid  input  1  qualifies In for this cycle.
- Out  output  16  registered sign-extended result (signed interpretation).
- SignRail  output  16  registered replication of the sign bit: all ones if the sign bit is 1, else all zeros.
- OutValid  output  1  high one cycle after an accepted InValid.

Behaviour:
- Combinational core:
  - ext[SIGN_BIT:0] = In[SIGN_BIT:0].
  - ext[15:SIGN_BIT+1] = {In[SIGN_BIT]} replicated.
  - rail = {16{In[SIGN_BIT]}}.
- In[15:SIGN_BIT+1] never influences any output.
- Interpreted as signed, Out equals In[SIGN_BIT:0] read as a (SIGN_BIT+1)-bit signed value, for every input.
- Rising edge with Reset=1: Out=0x0000, SignRail=0x0000, OutValid=0. Reset has priority over InValid.
- Rising edge with Reset=0 and InValid=1: Out<=ext, SignRail<=rail, OutValid<=1.
- Rising edge with Reset=0 and InValid=0: Out and SignRail hold their previous values; OutValid<=0.
- Latency is exactly 1 cycle from In/InValid sampled to Out/OutValid. Throughput is one result per cycle, with no backpressure.
- Reset asserted mid-stream: the result captured on that edge is discarded. Outputs read zero from the following cycle until new valid data is accepted after Reset deasserts.
- No X-propagation tolerance is required beyond normal synthesis semantics. All outputs are defined from the first reset onward.
- SIGN_BIT out of range is a configuration error. An elaboration-time check must flag it.

Test Plan:
- Reset: hold Reset=1 for 2 cycles with In=0xFFFF, InValid=1 -> Out=0x0000, SignRail=0x0000, OutValid=0. Deassert Reset -> next cycle Out=0xFFFF for SIGN_BIT=3.
- SIGN_BIT=3, exhaustive sweep In=0..15 with InValid=1 every cycle:
  - 0x0007 -> Out=0x0007, SignRail=0x0000.
  - 0x0008 -> Out=0xFFF8, SignRail=0xFFFF.
  - 0x000F -> Out=0xFFFF.
  - Each result appears exactly 1 cycle later.
- SIGN_BIT=7, sweep In=0..255:
  - 0x007F -> Out=0x007F.
  - 0x0080 -> Out=0xFF80.
  - 0x00F5 -> Out=0xFFF5.
- SIGN_BIT=10, sweep In=0..2047:
  - 0x03FF -> Out=0x03FF.
  - 0x0400 -> Out=0xFC00.
  - 0x07FF -> Out=0xFFFF.
- Upper-bit masking: SIGN_BIT=3 with In=0xABC5 -> Out=0x0005. SIGN_BIT=7 with In=0x1280 -> Out=0xFF80.
- Hold and valid: after Out=0xFFF8 (SIGN_BIT=3), drive InValid=0 with In=0x0001 for 3 cycles -> Out stays 0xFFF8 and OutValid=0. Assert Reset for one cycle mid-sequence -> Out=0x0000 the next cycle.

Source files
------------

// File: rtl/sign_extender.sv
// sign_extender: registered immediate sign extender for the MERC-16 datapath.
// The low SIGN_BIT+1 bits of In are a two's-complement immediate. They are
// widened to DATA_WIDTH bits and captured one clock after InValid. SignRail
// carries the replicated sign bit alongside the result.
module sign_extender #(
   parameter int DATA_WIDTH = 16,
   parameter int SIGN_BIT   = 3
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic [DATA_WIDTH-1:0] In,
   input  logic                  InValid,
   output logic [DATA_WIDTH-1:0] Out,
   output logic [DATA_WIDTH-1:0] SignRail,
   output logic                  OutValid
);

   // Reject unsupported configurations while the design is being elaborated.
   generate
      if (DATA_WIDTH != 16) begin : g_bad_width
         $error("sign_extender: DATA_WIDTH must be 16 (got %0d)", DATA_WIDTH);
      end
      if ((SIGN_BIT < 0) || (SIGN_BIT > DATA_WIDTH - 1)) begin : g_bad_sign_bit
         $error("sign_extender: SIGN_BIT %0d outside 0..%0d", SIGN_BIT, DATA_WIDTH - 1);
      end
   endgenerate

   logic                  sign;
   logic [DATA_WIDTH-1:0] ext;
   logic [DATA_WIDTH-1:0] rail;

   // Combinational core: keep bits up to the sign bit, fill everything above
   // it with the sign. A per-bit loop avoids an empty slice when SIGN_BIT is
   // the top bit, where the block degenerates to a plain register.
   always_comb begin
      // NOTE: every always_comb output gets a default before any conditional
      // logic, so no path can leave it unassigned and infer a latch.
      sign = In[SIGN_BIT];
      ext  = '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         ext[i] = (i <= SIGN_BIT) ? In[i] : sign;
      end
      rail = {DATA_WIDTH{sign}};
   end

   // Output register: reset wins over InValid. Results load only on valid
   // input and otherwise hold. OutValid is a one-cycle echo of InValid.
   always_ff @(posedge Clock) begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples pre-edge values, independent of statement order.
      if (Reset) begin
         Out      <= '0;
         SignRail <= '0;
         OutValid <= 1'b0;
      end else begin
         OutValid <= InValid;
         if (InValid) begin
            Out      <= ext;
            SignRail <= rail;
         end
      end
   end

endmodule

// File: tb/tb_sign_extender.sv
// tb_sign_extender: scoreboard bench for sign_extender at SIGN_BIT = 3, 7, 10.
// The stimulus process queues the expected result together with its issue
// cycle. A negedge monitor pops one entry per OutValid and compares the value,
// the rail, the originating instance and the one-cycle latency.
module tb_sign_extender;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] din  [3];
   logic        vin  [3];
   logic [15:0] dout [3];
   logic [15:0] rail [3];
   logic        vout [3];

   int cyc = 0;
   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      int          id;
      logic [15:0] out;
      logic [15:0] rail;
      int          cyc;
   } exp_t;

   typedef struct {
      int          id;
      logic [15:0] din;
      logic [15:0] out;
      logic [15:0] rail;
   } dir_t;

   exp_t sbq [$];
   dir_t dirs [14];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sign_extender #(.DATA_WIDTH(16), .SIGN_BIT(3)) u_sb3 (
      .Clock(clk), .Reset(rst), .In(din[0]), .InValid(vin[0]),
      .Out(dout[0]), .SignRail(rail[0]), .OutValid(vout[0]));

   sign_extender #(.DATA_WIDTH(16), .SIGN_BIT(7)) u_sb7 (
      .Clock(clk), .Reset(rst), .In(din[1]), .InValid(vin[1]),
      .Out(dout[1]), .SignRail(rail[1]), .OutValid(vout[1]));

   sign_extender #(.DATA_WIDTH(16), .SIGN_BIT(10)) u_sb10 (
      .Clock(clk), .Reset(rst), .In(din[2]), .InValid(vin[2]),
      .Out(dout[2]), .SignRail(rail[2]), .OutValid(vout[2]));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Arithmetic reference: take the low sb+1 bits and subtract 2^(sb+1) when
   // the value reaches 2^sb.
   function automatic logic [15:0] model_out(input int sb, input logic [15:0] v);
      int m;
      m = int'(v) & ((1 << (sb + 1)) - 1);
      if (m >= (1 << sb)) m = m - (1 << (sb + 1));
      return m[15:0];
   endfunction

   function automatic logic [15:0] model_rail(input int sb, input logic [15:0] v);
      int m;
      m = int'(v) & ((1 << (sb + 1)) - 1);
      return (m >= (1 << sb)) ? 16'hFFFF : 16'h0000;
   endfunction

   task automatic push(input int id, input logic [15:0] o, input logic [15:0] r);
      exp_t e;
      e.id   = id;
      e.out  = o;
      e.rail = r;
      e.cyc  = cyc;
      sbq.push_back(e);
   endtask

   task automatic drive_idle();
      for (int k = 0; k < 3; k++) vin[k] = 1'b0;
   endtask

   // One valid beat on instance id, issued just after the next rising edge.
   task automatic issue(input int id, input logic [15:0] v, input logic [15:0] o,
                        input logic [15:0] r);
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) vin[k] = (k == id);
      din[id] = v;
      push(id, o, r);
   endtask

   task automatic sweep(input int id, input int sb);
      int          n;
      logic [15:0] w;
      logic [15:0] junk;
      n    = 1 << (sb + 1);
      junk = 16'hA5A5 & ~(16'(n - 1));
      for (int v = 0; v < n; v++) begin
         w = 16'(v);
         if (v % 2 == 1) w = w | junk;
         issue(id, w, model_out(sb, w), model_rail(sb, w));
      end
   endtask

   // Monitor: every OutValid must match the oldest expected entry, come
   // from the right instance, and appear exactly one cycle after issue.
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (vout[i] === 1'b1) begin
            if (sbq.size() == 0) begin
               check($sformatf("spurious_valid[%0d]", i), 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               check("instance", 32'(i), 32'(e.id));
               check("latency_cycle", 32'(cyc), 32'(e.cyc + 1));
               check($sformatf("out[%0d]", i), {16'h0, dout[i]}, {16'h0, e.out});
               check($sformatf("rail[%0d]", i), {16'h0, rail[i]}, {16'h0, e.rail});
            end
         end
      end
   end

   initial begin
      dirs = '{
         '{0, 16'h0007, 16'h0007, 16'h0000},
         '{0, 16'h0008, 16'hFFF8, 16'hFFFF},
         '{0, 16'h000F, 16'hFFFF, 16'hFFFF},
         '{0, 16'hABC5, 16'h0005, 16'h0000},
         '{1, 16'h007F, 16'h007F, 16'h0000},
         '{1, 16'h0080, 16'hFF80, 16'hFFFF},
         '{1, 16'h00F5, 16'hFFF5, 16'hFFFF},
         '{1, 16'h1280, 16'hFF80, 16'hFFFF},
         '{2, 16'h03FF, 16'h03FF, 16'h0000},
         '{2, 16'h0400, 16'hFC00, 16'hFFFF},
         '{2, 16'h07FF, 16'hFFFF, 16'hFFFF},
         '{2, 16'hF800, 16'h0000, 16'h0000},
         '{2, 16'h8C01, 16'hFC01, 16'hFFFF},
         '{0, 16'hFFF7, 16'h0007, 16'h0000}
      };

      // Reset held two edges with valid all-ones input on every instance.
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         din[k] = 16'hFFFF;
         vin[k] = 1'b1;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("reset_out[%0d]", k), {16'h0, dout[k]}, 32'h0);
         check($sformatf("reset_rail[%0d]", k), {16'h0, rail[k]}, 32'h0);
         check($sformatf("reset_valid[%0d]", k), {31'h0, vout[k]}, 32'h0);
      end

      // Release reset with 0xFFFF still valid on the SIGN_BIT=3 instance.
      rst = 1'b0;
      vin[1] = 1'b0;
      vin[2] = 1'b0;
      push(0, 16'hFFFF, 16'hFFFF);

      // Hold: capture 0xFFF8, then idle with a different In.
      issue(0, 16'h0008, 16'hFFF8, 16'hFFFF);
      @(posedge clk);
      #1;
      drive_idle();
      din[0] = 16'h0001;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         check("hold_out", {16'h0, dout[0]}, 32'h0000FFF8);
         check("hold_rail", {16'h0, rail[0]}, 32'h0000FFFF);
         check("hold_valid", {31'h0, vout[0]}, 32'h0);
      end

      // Mid-sequence reset with valid input present: the beat is discarded.
      rst = 1'b1;
      vin[0] = 1'b1;
      din[0] = 16'h0005;
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive_idle();
      for (int c = 0; c < 2; c++) begin
         check("midreset_out", {16'h0, dout[0]}, 32'h0);
         check("midreset_rail", {16'h0, rail[0]}, 32'h0);
         check("midreset_valid", {31'h0, vout[0]}, 32'h0);
         @(posedge clk);
         #1;
      end

      // Full sweeps, with odd vectors carrying junk above the immediate.
      sweep(0, 3);
      sweep(1, 7);
      sweep(2, 10);

      // Hand-computed directed vectors, streamed back to back.
      foreach (dirs[j]) issue(dirs[j].id, dirs[j].din, dirs[j].out, dirs[j].rail);

      // Drain with a bounded wait.
      @(posedge clk);
      #1;
      drive_idle();
      for (int c = 0; c < 10 && sbq.size() != 0; c++) @(posedge clk);
      @(negedge clk);
      check("pending_results", 32'(sbq.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
